pwm_deadtime: RTL

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
//   Converts CHANNELS raw PWM signals into complementary high-side / low-side
//   gate drives with a programmable dead time between them. Each channel has
//   its own FSM (OFF, LS_ON, DT_LH, HS_ON, DT_HL) and its own dead-time
//   down-counter. hs_out/ls_out are registered and are never both high.
//
// Ports
//   clk           single clock for all logic
//   rst_n         asynchronous active-low reset (all channels OFF, outputs 0)
//   enable        0 forces every channel to OFF with both outputs 0
//   dead_time     dead-time length in clk cycles, sampled when an interval starts
//   pwm_in        raw PWM per channel (same clock domain)
//   hs_out        high-side gate drive per channel (registered)
//   ls_out        low-side gate drive per channel (registered)
//
// Optional feature (macro PWM_DEADTIME_FAULT_EN)
//   fault_n       active-low trip input; trips the latch and forces OFF
//   fault_clr     clears the latch when fault_n is high
//   fault_latched registered fault latch; channels stay OFF while it is set
// -----------------------------------------------------------------------------
module pwm_deadtime #(
    parameter int CHANNELS = 3,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic [CHANNELS-1:0] pwm_in,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic                fault_n,
    input  logic                fault_clr,
    output logic                fault_latched,
`endif
    output logic [CHANNELS-1:0] hs_out,
    output logic [CHANNELS-1:0] ls_out
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        LS_ON = 3'd1,
        DT_LH = 3'd2,
        HS_ON = 3'd3,
        DT_HL = 3'd4
    } state_t;

    localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);
    localparam logic [DT_WIDTH-1:0] DT_ZERO = '0;

    logic w_force_off;

`ifdef PWM_DEADTIME_FAULT_EN
    logic r_fault;

    // A trip wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (!fault_n) begin
            r_fault <= 1'b1;
        end else if (fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign fault_latched = r_fault;
    // The live trip forces OFF at the sampling edge itself; the latch holds
    // channels OFF afterwards, including the edge at which it clears.
    assign w_force_off   = ~enable | ~fault_n | r_fault;
`else
    assign w_force_off   = ~enable;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t              r_state;
        state_t              w_state_nxt;
        logic [DT_WIDTH-1:0] r_cnt;
        logic [DT_WIDTH-1:0] w_cnt_nxt;
        logic                r_hs;
        logic                r_ls;

        // The counter holds the number of dead cycles still to run, counting
        // the current one; the swap happens on the edge that sees 1 (or 0,
        // reachable only via OFF with dead_time=0), so D gives D dead cycles.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            unique case (r_state)
                OFF: begin
                    if (pwm_in[g]) begin
                        w_state_nxt = DT_LH;
                        w_cnt_nxt   = dead_time;
                    end else begin
                        w_state_nxt = LS_ON;
                    end
                end
                LS_ON: begin
                    if (pwm_in[g]) begin
                        if (dead_time == DT_ZERO) begin
                            w_state_nxt = HS_ON;
                        end else begin
                            w_state_nxt = DT_LH;
                            w_cnt_nxt   = dead_time;
                        end
                    end
                end
                DT_LH: begin
                    if (!pwm_in[g]) begin
                        w_state_nxt = LS_ON;
                    end else if (r_cnt <= DT_ONE) begin
                        w_state_nxt = HS_ON;
                    end else begin
                        w_cnt_nxt   = r_cnt - DT_ONE;
                    end
                end
                HS_ON: begin
                    if (!pwm_in[g]) begin
                        if (dead_time == DT_ZERO) begin
                            w_state_nxt = LS_ON;
                        end else begin
                            w_state_nxt = DT_HL;
                            w_cnt_nxt   = dead_time;
                        end
                    end
                end
                DT_HL: begin
                    if (pwm_in[g]) begin
                        w_state_nxt = HS_ON;
                    end else if (r_cnt <= DT_ONE) begin
                        w_state_nxt = LS_ON;
                    end else begin
                        w_cnt_nxt   = r_cnt - DT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end
            endcase

            if (w_force_off) begin
                w_state_nxt = OFF;
                w_cnt_nxt   = '0;
            end
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state, which keeps them in step with the FSM.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= OFF;
                r_cnt   <= '0;
                r_hs    <= 1'b0;
                r_ls    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_hs    <= (w_state_nxt == HS_ON);
                r_ls    <= (w_state_nxt == LS_ON);
            end
        end

        assign hs_out[g] = r_hs;
        assign ls_out[g] = r_ls;
    end

endmodule
